// File: rtl/lfsr_data_checker_if.sv
// Valid/Data stream between the LFSR data generator and its checker.
// The generator drives through the master modport, the checker samples through slave.
interface lfsr_data_checker_if #(
    parameter int DATA_SIZE = 4
);
    logic                 Valid;
    logic [DATA_SIZE-1:0] Data;

    modport master (output Valid, output Data);
    modport slave  (input  Valid, input  Data);
endinterface

// File: rtl/lfsr_data_checker.sv
// LFSR stream checker: regenerates the generator's 16-bit sequence locally,
// compares every valid word against its low DATA_SIZE bits, and reports
// per-word mismatch pulses, saturating counters, the first error index and a
// lock/fail status.
module lfsr_data_checker #(
    parameter int          DATA_SIZE   = 4,
    parameter logic [15:0] SEED        = 16'hABCD,
    parameter int          FAIL_THRESH = 8,
    parameter int          CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    lfsr_data_checker_if.slave   stream,
    input  logic                 clear,
    output logic                 err,
    output logic                 locked,
    output logic                 fail,
    output logic [CNT_W-1:0]     word_cnt,
    output logic [CNT_W-1:0]     err_cnt,
    output logic [CNT_W-1:0]     first_err_idx
);

    // The checked word is a slice of a 16-bit LFSR, so wider words cannot exist.
    generate
        if (DATA_SIZE < 1 || DATA_SIZE > 16) begin : g_bad_data_size
            $error("lfsr_data_checker: DATA_SIZE must be in 1..16");
        end
        if (FAIL_THRESH < 1) begin : g_bad_fail_thresh
            $error("lfsr_data_checker: FAIL_THRESH must be at least 1");
        end
    endgenerate

    localparam int CONSEC_W = $clog2(FAIL_THRESH + 1);
    localparam logic [CONSEC_W-1:0] CONSEC_MAX = CONSEC_W'(FAIL_THRESH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_FAIL  = 2'd2;

    logic [15:0]         lfsr;
    logic [15:0]         lfsr_next;
    logic                fb;
    logic                mismatch;
    logic [1:0]          state;
    logic [1:0]          state_next;
    logic [CONSEC_W-1:0] consec_err;
    logic [CONSEC_W-1:0] consec_next;
    logic                have_err;

    // XNOR feedback from taps 12,3,1,0; shift toward bit 0.
    assign fb        = ~(lfsr[12] ^ lfsr[3] ^ lfsr[1] ^ lfsr[0]);
    assign lfsr_next = {fb, lfsr[15:1]};

    // Expected word is the current LFSR value, compared in the same cycle as Valid.
    assign mismatch = stream.Valid && (stream.Data != lfsr[DATA_SIZE-1:0]);

    assign locked = (state == ST_CHECK);
    assign fail   = (state == ST_FAIL);

    // Next consecutive-error count and FSM state for the word presented this cycle.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned, which would infer a latch.
        consec_next = consec_err;
        state_next  = state;
        if (stream.Valid) begin
            if (mismatch) begin
                if (consec_err != CONSEC_MAX) begin
                    consec_next = consec_err + 1'b1;
                end
            end else begin
                consec_next = '0;
            end
            // FAIL is only left through clear or rst.
            if (state != ST_FAIL) begin
                state_next = (consec_next == CONSEC_MAX) ? ST_FAIL : ST_CHECK;
            end
        end
    end

    // Local LFSR: advances on each valid word, reseeds whenever the stream idles.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (rst) begin
            lfsr <= SEED;
        end else if (clear || !stream.Valid) begin
            lfsr <= SEED;
        end else begin
            lfsr <= lfsr_next;
        end
    end

    // FSM and consecutive-mismatch tracker; consec_err survives Valid gaps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            consec_err <= '0;
        end else if (clear) begin
            state      <= ST_IDLE;
            consec_err <= '0;
        end else begin
            state      <= state_next;
            consec_err <= consec_next;
        end
    end

    // One-cycle error pulse for the word checked on the previous cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (clear) begin
            err <= 1'b0;
        end else begin
            err <= mismatch;
        end
    end

    // Word and error counters, each saturating independently at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_cnt <= '0;
            err_cnt  <= '0;
        end else if (clear) begin
            word_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            if (stream.Valid && word_cnt != '1) begin
                word_cnt <= word_cnt + 1'b1;
            end
            if (mismatch && err_cnt != '1) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

    // First mismatch index: pre-increment word_cnt, held until rst/clear.
    // A separate flag is kept because all-ones is also a legal saturated index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_err_idx <= '1;
            have_err      <= 1'b0;
        end else if (clear) begin
            first_err_idx <= '1;
            have_err      <= 1'b0;
        end else if (mismatch && !have_err) begin
            first_err_idx <= word_cnt;
            have_err      <= 1'b1;
        end
    end

endmodule

// File: tb/tb_lfsr_data_checker.sv
// Directed bench for lfsr_data_checker: a bench-side generator drives the
// stream, expected err pulses go through a scoreboard queue, and counters and
// status are compared against hand-derived values at checkpoints.
module tb_lfsr_data_checker;

    localparam logic [15:0] SEED = 16'hABCD;
    localparam logic [31:0] ALL1 = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    logic rst;
    logic clear;
    logic clear2;

    logic        err, locked, fail;
    logic [31:0] word_cnt, err_cnt, first_err_idx;
    logic        err2, locked2, fail2;
    logic [3:0]  word_cnt2, err_cnt2, first_err_idx2;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] g_lfsr;
    logic [15:0] g2_lfsr;
    logic        exp_q[$];

    always #5 clk = ~clk;

    lfsr_data_checker_if #(.DATA_SIZE(4)) bus  ();
    lfsr_data_checker_if #(.DATA_SIZE(4)) bus2 ();

    lfsr_data_checker #(
        .DATA_SIZE(4), .SEED(SEED), .FAIL_THRESH(8), .CNT_W(32)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .stream        (bus),
        .clear         (clear),
        .err           (err),
        .locked        (locked),
        .fail          (fail),
        .word_cnt      (word_cnt),
        .err_cnt       (err_cnt),
        .first_err_idx (first_err_idx)
    );

    lfsr_data_checker #(
        .DATA_SIZE(4), .SEED(SEED), .FAIL_THRESH(8), .CNT_W(4)
    ) u_dut_sat (
        .clk           (clk),
        .rst           (rst),
        .stream        (bus2),
        .clear         (clear2),
        .err           (err2),
        .locked        (locked2),
        .fail          (fail2),
        .word_cnt      (word_cnt2),
        .err_cnt       (err_cnt2),
        .first_err_idx (first_err_idx2)
    );

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        logic x;
        x = l[12] ^ l[3] ^ l[1] ^ l[0];
        return {~x, l[15:1]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one valid word with explicit data; expected err pulse is queued.
    task automatic send_raw(input logic [3:0] d, input logic exp_err);
        logic e;
        bus.Valid = 1'b1;
        bus.Data  = d;
        exp_q.push_back(exp_err);
        @(posedge clk);
        g_lfsr = lfsr_step(g_lfsr);
        #1;
        e = exp_q.pop_front();
        check("err", {31'b0, err}, {31'b0, e});
    endtask

    // Drive the next generator word, optionally with bit 0 flipped.
    task automatic send(input logic corrupt);
        send_raw(g_lfsr[3:0] ^ {3'b000, corrupt}, corrupt);
    endtask

    // Idle cycles: generator reseeds, no err pulse may appear.
    task automatic idle(input int n);
        bus.Valid = 1'b0;
        bus.Data  = '0;
        g_lfsr    = SEED;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check("err_idle", {31'b0, err}, 32'd0);
        end
    endtask

    initial begin
        rst        = 1'b1;
        clear      = 1'b0;
        clear2     = 1'b0;
        bus.Valid  = 1'b0;
        bus.Data   = '0;
        bus2.Valid = 1'b0;
        bus2.Data  = '0;
        g_lfsr     = SEED;
        g2_lfsr    = SEED;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_locked", {31'b0, locked}, 32'd0);
        check("rst_fail", {31'b0, fail}, 32'd0);
        check("rst_word_cnt", word_cnt, 32'd0);
        check("rst_err_cnt", err_cnt, 32'd0);
        check("rst_first_err", first_err_idx, ALL1);
        rst = 1'b0;

        // Golden stream D,6,3
        send_raw(4'hD, 1'b0);
        check("golden_locked", {31'b0, locked}, 32'd1);
        send_raw(4'h6, 1'b0);
        send_raw(4'h3, 1'b0);
        check("golden_word_cnt", word_cnt, 32'd3);
        check("golden_err_cnt", err_cnt, 32'd0);
        check("golden_first_err", first_err_idx, ALL1);

        // Clear with Valid low, then 20 words with word 5 corrupted
        bus.Valid = 1'b0;
        clear     = 1'b1;
        @(posedge clk);
        #1;
        clear  = 1'b0;
        g_lfsr = SEED;
        check("clr_word_cnt", word_cnt, 32'd0);
        check("clr_locked", {31'b0, locked}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            send(i == 5);
            if (i == 0) check("flip_locked0", {31'b0, locked}, 32'd1);
        end
        check("flip_word_cnt", word_cnt, 32'd20);
        check("flip_err_cnt", err_cnt, 32'd1);
        check("flip_first_err", first_err_idx, 32'd5);
        check("flip_locked", {31'b0, locked}, 32'd1);

        // Valid gap of 3 cycles, generator restarts from the seed
        idle(3);
        for (int i = 0; i < 5; i++) send(1'b0);
        check("gap_word_cnt", word_cnt, 32'd25);
        check("gap_err_cnt", err_cnt, 32'd1);
        check("gap_locked", {31'b0, locked}, 32'd1);

        // 7 consecutive mismatches then a good word: no FAIL
        for (int i = 0; i < 7; i++) send(1'b1);
        send(1'b0);
        check("seven_fail", {31'b0, fail}, 32'd0);
        check("seven_locked", {31'b0, locked}, 32'd1);
        check("seven_err_cnt", err_cnt, 32'd8);
        check("seven_first_err", first_err_idx, 32'd5);

        // 10 good then 8 consecutive mismatches: FAIL after the 8th
        for (int i = 0; i < 10; i++) send(1'b0);
        for (int i = 0; i < 8; i++) begin
            send(1'b1);
            if (i == 6) check("thresh_fail_at7", {31'b0, fail}, 32'd0);
        end
        check("thresh_fail", {31'b0, fail}, 32'd1);
        check("thresh_locked", {31'b0, locked}, 32'd0);
        check("thresh_err_cnt", err_cnt, 32'd16);
        check("thresh_word_cnt", word_cnt, 32'd51);

        // In FAIL the checker keeps comparing and counting
        send(1'b1);
        check("failrun_fail", {31'b0, fail}, 32'd1);
        check("failrun_word_cnt", word_cnt, 32'd52);
        check("failrun_err_cnt", err_cnt, 32'd17);

        // Clear with Valid high: word dropped, everything back to reset values
        bus.Valid = 1'b1;
        bus.Data  = g_lfsr[3:0] ^ 4'h1;
        clear     = 1'b1;
        @(posedge clk);
        #1;
        clear  = 1'b0;
        g_lfsr = SEED;
        check("clrv_err", {31'b0, err}, 32'd0);
        check("clrv_fail", {31'b0, fail}, 32'd0);
        check("clrv_locked", {31'b0, locked}, 32'd0);
        check("clrv_word_cnt", word_cnt, 32'd0);
        check("clrv_err_cnt", err_cnt, 32'd0);
        check("clrv_first_err", first_err_idx, ALL1);
        send(1'b0);
        send(1'b0);
        check("postclr_locked", {31'b0, locked}, 32'd1);
        check("postclr_word_cnt", word_cnt, 32'd2);

        // Async reset mid-word: outputs clear without a clock edge
        bus.Valid = 1'b1;
        bus.Data  = g_lfsr[3:0];
        #3;
        rst = 1'b1;
        #1;
        check("arst_word_cnt", word_cnt, 32'd0);
        check("arst_locked", {31'b0, locked}, 32'd0);
        check("arst_first_err", first_err_idx, ALL1);
        bus.Valid = 1'b0;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        g_lfsr = SEED;
        send(1'b0);
        check("postrst_locked", {31'b0, locked}, 32'd1);
        send(1'b0);
        send(1'b0);
        check("postrst_word_cnt", word_cnt, 32'd3);
        check("postrst_err_cnt", err_cnt, 32'd0);

        // Saturation with CNT_W=4: 20 corrupted words
        bus.Valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bus2.Valid = 1'b1;
            bus2.Data  = g2_lfsr[3:0] ^ 4'h1;
            @(posedge clk);
            g2_lfsr = lfsr_step(g2_lfsr);
            #1;
            check("sat_err", {31'b0, err2}, 32'd1);
            if (i == 14) check("sat_word_cnt15", {28'b0, word_cnt2}, 32'd15);
        end
        bus2.Valid = 1'b0;
        check("sat_word_cnt", {28'b0, word_cnt2}, 32'd15);
        check("sat_err_cnt", {28'b0, err_cnt2}, 32'd15);
        check("sat_first_err", {28'b0, first_err_idx2}, 32'd0);
        check("sat_fail", {31'b0, fail2}, 32'd1);
        check("sat_locked", {31'b0, locked2}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lfsr_data_checker.md
Name: lfsr_data_checker

Overview:
- Sink stage directly downstream of the LFSR data generator. Consumes its Valid/Data stream.
- Regenerates the identical 16-bit pseudo-random sequence locally and compares every valid word against it.
- Reports per-word mismatches, running counters, first-error index, and a lock/fail status for bring-up and link checking.

Parameters:
DATA_SIZE, 4, width of checked data word (1..16), taken from the low bits of the LFSR
SEED, 16'hABCD, LFSR load value, must equal the generator seed
FAIL_THRESH, 8, consecutive mismatches that force FAIL state
CNT_W, 32, width of word and error counters

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
Valid  in  1  stream qualifier from generator
Data  in  DATA_SIZE  stream word from generator
clear  in  1  synchronous clear of counters, status and FSM (to IDLE)
err  out  1  one-cycle pulse: registered mismatch for previous valid word
locked  out  1  high in CHECK state
fail  out  1  high in FAIL state (sticky until clear/rst)
word_cnt  out  CNT_W  valid words checked, saturating
err_cnt  out  CNT_W  mismatched words, saturating
first_err_idx  out  CNT_W  word_cnt value of first mismatch; all-ones if none

Behaviour:
- Reset (rst high, async): lfsr=SEED, state=IDLE, err=0, locked=0, fail=0, word_cnt=0, err_cnt=0, first_err_idx=all-ones, consec_err=0.
- Local LFSR: when Valid=0, lfsr<=SEED. When Valid=1, lfsr<={fb, lfsr[15:1]}, fb = XNOR of lfsr bits 12,3,1,0 (fb=1 when XOR=0).
- Expected word = lfsr[DATA_SIZE-1:0] in the same cycle Valid=1. Compare Data to it combinationally and register the result.
- Latency: err, counters and state update on the clock edge ending the valid cycle, i.e. visible 1 cycle after Valid/Data.
- FSM:
  - IDLE: first Valid=1 -> CHECK. That word is already compared and counted.
  - CHECK: each valid word increments word_cnt. A mismatch increments err_cnt and consec_err, and a match zeroes consec_err. When consec_err reaches FAIL_THRESH -> FAIL.
  - Valid low in CHECK keeps the state; the LFSR reseeds per the rule above, consec_err is preserved.
  - FAIL: fail=1, locked=0. Compare and counters keep running, err still pulses. Leaves only on clear or rst.
- first_err_idx: captured = word_cnt value before increment on the first mismatch since reset/clear. Index is 0-based. Held thereafter.
- Counters saturate at all-ones, no wrap. err_cnt and word_cnt saturate independently.
- clear has priority over Valid in the same cycle. Everything returns to reset values, lfsr=SEED, and the word arriving that cycle is dropped (not counted).
- rst asserted mid-stream: immediate return to reset values. After release, the checker re-enters CHECK on the next Valid=1 word, expected = SEED low bits.
- Width: DATA_SIZE>16 is illegal. Handle it with an elaboration-time error.

Test Plan:
- Golden stream: rst then Valid=1 with Data 4'hD,4'h6,4'h3 (SEED ABCD, DATA_SIZE=4) -> err never pulses, locked=1 one cycle after first word, word_cnt=3, err_cnt=0, first_err_idx=all-ones.
- Single flip: corrupt word index 5 (Data XOR 1) of a 20-word golden stream -> err pulses once a cycle after word 5, err_cnt=1, first_err_idx=5, locked stays 1.
- Fail threshold: 8 consecutive corrupted words after 10 good -> fail=1, locked=0 after 8th; 7 consecutive then a good word -> no fail, consec reset.
- Valid gap: Valid drops for 3 cycles mid-stream, generator reseeds and restarts at 4'hD -> no errors, word_cnt continues accumulating.
- Clear/reset: in FAIL assert clear with Valid=1 -> next cycle state IDLE, counters 0, that word not counted. Async rst mid-word -> outputs reset without clock edge.
- Saturation: CNT_W=4, 20 corrupted words -> err_cnt and word_cnt hold at 15.
